// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC generation, one-cycle memory latency absorption and a
// 2-entry skid buffer toward decode. Optional halt-on-zero detection via FETCH_HALT_DETECT_EN.
module fetch_sequencer #(
  parameter int unsigned PC_W      = 20,
  parameter int unsigned INS_W     = 20,
  parameter int unsigned MEM_DEPTH = 20,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [PC_W-1:0]  imem_pc,
  input  logic [INS_W-1:0] imem_ins,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INS_W-1:0] out_ins,
  output logic [PC_W-1:0]  out_pc,
  output logic             halted,
  output logic             fault
);

`ifdef FETCH_HALT_DETECT_EN
  typedef enum logic [1:0] {StIdle, StRun, StHalt, StFault} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRun, StFault} state_e;
`endif

  state_e           state_q, state_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  tag_pc_q, tag_pc_d;
  logic             inflight_q, inflight_d;
  logic             fault_q, fault_d;
  logic [1:0]       count_q, count_d;
  logic [INS_W-1:0] ent0_ins_q, ent0_ins_d, ent1_ins_q, ent1_ins_d;
  logic [PC_W-1:0]  ent0_pc_q, ent0_pc_d, ent1_pc_q, ent1_pc_d;

  logic       pop, push, issue, oob, halt_cap;
  logic [2:0] occ_after;
  logic [1:0] push_idx;

  assign pop       = (count_q != 2'd0) && out_ready;
  assign oob       = fetch_pc_q >= PC_W'(MEM_DEPTH);
  // Occupancy once the in-flight read lands and the head pop retires; must leave room.
  assign occ_after = 3'(count_q) + 3'(inflight_q) - 3'(pop);

`ifdef FETCH_HALT_DETECT_EN
  assign halt_cap = inflight_q && (imem_ins == '0);
`else
  assign halt_cap = 1'b0;
`endif

  assign push  = inflight_q && !halt_cap && !redirect_valid;
  assign issue = (state_q == StRun) && !redirect_valid && !oob && !halt_cap &&
                 (occ_after < 3'd2);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    tag_pc_d   = tag_pc_q;
    inflight_d = issue;
    fault_d    = fault_q;
    if (redirect_valid) begin
      state_d    = StRun;
      fetch_pc_d = redirect_pc;
      fault_d    = 1'b0;
    end else begin
      case (state_q)
        StIdle: if (start) state_d = StRun;
        StRun: begin
          if (halt_cap) begin
`ifdef FETCH_HALT_DETECT_EN
            state_d = StHalt;
`endif
          end else if (oob) begin
            state_d = StFault;
            fault_d = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
      if (issue) begin
        fetch_pc_d = fetch_pc_q + PC_W'(1);
        tag_pc_d   = fetch_pc_q;
      end
    end
  end

  // Head is always entry 0; a pop shifts entry 1 down before the tail write.
  always_comb begin
    ent0_ins_d = ent0_ins_q;
    ent0_pc_d  = ent0_pc_q;
    ent1_ins_d = ent1_ins_q;
    ent1_pc_d  = ent1_pc_q;
    count_d    = count_q;
    push_idx   = count_q - 2'(pop);
    if (redirect_valid) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        ent0_ins_d = ent1_ins_q;
        ent0_pc_d  = ent1_pc_q;
      end
      if (push) begin
        if (push_idx == 2'd0) begin
          ent0_ins_d = imem_ins;
          ent0_pc_d  = tag_pc_q;
        end else begin
          ent1_ins_d = imem_ins;
          ent1_pc_d  = tag_pc_q;
        end
      end
      count_d = count_q - 2'(pop) + 2'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= PC_W'(RESET_PC);
      tag_pc_q   <= '0;
      inflight_q <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= 2'd0;
      ent0_ins_q <= '0;
      ent0_pc_q  <= '0;
      ent1_ins_q <= '0;
      ent1_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      tag_pc_q   <= tag_pc_d;
      inflight_q <= inflight_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
      ent0_ins_q <= ent0_ins_d;
      ent0_pc_q  <= ent0_pc_d;
      ent1_ins_q <= ent1_ins_d;
      ent1_pc_q  <= ent1_pc_d;
    end
  end

  assign imem_pc   = fetch_pc_q;
  assign out_valid = count_q != 2'd0;
  assign out_ins   = ent0_ins_q;
  assign out_pc    = ent0_pc_q;
  assign fault     = fault_q;

`ifdef FETCH_HALT_DETECT_EN
  assign halted = (state_q == StHalt) && (count_q == 2'd0);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: startup latency, stall, redirect, fault and reset cases
// against a registered-read memory model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, redirect_valid, out_ready;
  logic [19:0] imem_pc, imem_ins, redirect_pc, out_ins, out_pc;
  logic        out_valid, halted, fault;
  logic [19:0] mem [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .imem_pc        (imem_pc),
    .imem_ins       (imem_ins),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ins        (out_ins),
    .out_pc         (out_pc),
    .halted         (halted),
    .fault          (fault)
  );

  function automatic logic [19:0] memword(input int i);
    return (i == 7) ? 20'h0 : 20'(32'hA5000 + i * 32'h111);
  endfunction

  initial begin
    imem_ins = '0;
    for (int i = 0; i < 32; i++) mem[i] = memword(i);
  end

  always @(posedge clk) imem_ins <= mem[imem_pc[4:0]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    step();
    step();
    chk("rst_imem_pc", 32'(imem_pc), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_ins", 32'(out_ins), 0);
    chk("rst_out_pc", 32'(out_pc), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_fault", 32'(fault), 0);
    rst = 1'b0;

    // Startup and streaming
    start = 1'b1;
    step();
    start = 1'b0;
    chk("e0_valid", 32'(out_valid), 0);
    step();
    chk("e1_valid", 32'(out_valid), 0);
    chk("e1_imem_pc", 32'(imem_pc), 1);
    step();
    for (int i = 0; i < 7; i++) begin
      chk("stream_valid", 32'(out_valid), 1);
      chk("stream_pc", 32'(out_pc), 32'(i));
      chk("stream_ins", 32'(out_ins), 32'(memword(i)));
      step();
    end
`ifdef FETCH_HALT_DETECT_EN
    chk("halt_valid", 32'(out_valid), 0);
    chk("halt_halted", 32'(halted), 1);
`else
    chk("zero_valid", 32'(out_valid), 1);
    chk("zero_pc", 32'(out_pc), 7);
    chk("zero_ins", 32'(out_ins), 0);
    chk("zero_halted", 32'(halted), 0);
`endif

    // Redirect to 0 with decoder stalled
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 20'd0;
    step();
    redirect_valid = 1'b0;
    chk("rd0_valid0", 32'(out_valid), 0);
    chk("rd0_halted", 32'(halted), 0);
    step();
    chk("rd0_valid1", 32'(out_valid), 0);
    chk("rd0_imem_pc", 32'(imem_pc), 1);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_pc", 32'(out_pc), 0);
      chk("stall_ins", 32'(out_ins), 32'(memword(0)));
      chk("stall_imem_pc", 32'(imem_pc), 2);
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("release_valid", 32'(out_valid), 1);
      chk("release_pc", 32'(out_pc), 32'(k));
      step();
    end

    // Mid-stream redirect to 12
    redirect_valid = 1'b1; redirect_pc = 20'd12;
    step();
    redirect_valid = 1'b0;
    chk("rd12_gap0", 32'(out_valid), 0);
    step();
    chk("rd12_gap1", 32'(out_valid), 0);
    step();
    chk("rd12_valid", 32'(out_valid), 1);
    chk("rd12_pc", 32'(out_pc), 12);
    chk("rd12_ins", 32'(out_ins), 32'(memword(12)));
    step();
    chk("rd12_next_pc", 32'(out_pc), 13);

    // Last legal PC then fault
    redirect_valid = 1'b1; redirect_pc = 20'd19;
    step();
    redirect_valid = 1'b0;
    chk("f_gap0", 32'(out_valid), 0);
    step();
    chk("f_gap1", 32'(out_valid), 0);
    chk("f_imem_pc", 32'(imem_pc), 20);
    chk("f_fault_early", 32'(fault), 0);
    step();
    chk("f_valid19", 32'(out_valid), 1);
    chk("f_pc19", 32'(out_pc), 19);
    chk("f_ins19", 32'(out_ins), 32'(memword(19)));
    step();
    chk("f_after_valid", 32'(out_valid), 0);
    chk("f_fault", 32'(fault), 1);
    chk("f_hold_pc", 32'(imem_pc), 20);
    step();
    chk("f_after_valid2", 32'(out_valid), 0);
    chk("f_fault2", 32'(fault), 1);
    redirect_valid = 1'b1; redirect_pc = 20'd0;
    step();
    redirect_valid = 1'b0;
    chk("fc_fault", 32'(fault), 0);
    chk("fc_valid", 32'(out_valid), 0);
    step();
    step();
    chk("fc_restart_valid", 32'(out_valid), 1);
    chk("fc_restart_pc", 32'(out_pc), 0);

    // Reset during a stall
    out_ready = 1'b0;
    step();
    step();
    chk("pre_rst_pc", 32'(out_pc), 0);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_imem_pc", 32'(imem_pc), 0);
    chk("mid_rst_fault", 32'(fault), 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_valid", 32'(out_valid), 0);
      chk("idle_imem_pc", 32'(imem_pc), 0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("restart_valid", 32'(out_valid), 1);
    chk("restart_pc", 32'(out_pc), 0);
    chk("restart_ins", 32'(out_ins), 32'(memword(0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
